alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 45 ++++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter.
// The master side is the requester/consumer environment.
// The slave side is the arbiter itself.
interface alu_arbiter_if #(
    parameter int WIDTH = 16
);
    // Requester A
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_num1;
    logic [WIDTH-1:0] a_num2;
    logic [3:0]       a_opcode;

    // Requester B
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_num1;
    logic [WIDTH-1:0] b_num2;
    logic [3:0]       b_opcode;

    // Response channel and status
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_illegal;
    logic             busy;
    logic [15:0]      op_count;

    modport master (
        output a_valid, a_num1, a_num2, a_opcode,
        output b_valid, b_num1, b_num2, b_opcode,
        output rsp_ready,
        input  a_ready, b_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_illegal, busy, op_count
    );

    modport slave (
        input  a_valid, a_num1, a_num2, a_opcode,
        input  b_valid, b_num1, b_num2, b_opcode,
        input  rsp_ready,
        output a_ready, b_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_illegal, busy, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester ALU arbiter.
// It grants one of A/B in IDLE with a round-robin tie-break.
// It computes the latched operation in a single EXEC cycle.
// It holds the result in RESP until the consumer takes it.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_ptr;        // 0 = A has priority on a tie, 1 = B
    logic [WIDTH-1:0] r_num1;
    logic [WIDTH-1:0] r_num2;
    logic [3:0]       r_opcode;
    logic             r_id;

    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_id;
    logic             r_rsp_illegal;
    logic [15:0]      r_op_count;

    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_accept;
    logic             w_done;
    logic             w_rsp_valid;
    logic             w_busy;
    logic [WIDTH-1:0] w_result;
    logic             w_illegal;

    // Grant selection: only in IDLE, a lone requester wins, and a tie goes to the pointer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (r_state == IDLE) begin
            if (bus.a_valid && (!bus.b_valid || !r_ptr)) begin
                w_grant_a = 1'b1;
            end else if (bus.b_valid) begin
                w_grant_b = 1'b1;
            end
        end
    end

    assign w_accept = w_grant_a | w_grant_b;
    assign w_done   = (r_state == RESP) && bus.rsp_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and state-decoded outputs.
    always_comb begin
        w_next_state = r_state;
        w_rsp_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_accept) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ALU on the latched operands. Add and subtract wrap at WIDTH bits.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (r_opcode)
            4'b0001: w_result = r_num1 + r_num2;
            4'b0010: w_result = r_num1 - r_num2;
            4'b0011: w_result = r_num1 & r_num2;
            4'b0100: w_result = r_num1 | r_num2;
            4'b0101: w_result = r_num1 ^ r_num2;
            default: w_illegal = 1'b1;
        endcase
    end

    // Capture the granted requester's operation on the handshake edge.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the datapath registers are reset too, because the latched operands must read zero while reset is high.
        if (reset) begin
            r_num1   <= '0;
            r_num2   <= '0;
            r_opcode <= '0;
            r_id     <= 1'b0;
        end else if (w_accept) begin
            r_num1   <= w_grant_a ? bus.a_num1   : bus.b_num1;
            r_num2   <= w_grant_a ? bus.a_num2   : bus.b_num2;
            r_opcode <= w_grant_a ? bus.a_opcode : bus.b_opcode;
            r_id     <= w_grant_b;
        end
    end

    // Register the result in EXEC. It then stays frozen through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_data    <= '0;
            r_rsp_id      <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_data    <= w_result;
            r_rsp_id      <= r_id;
            r_rsp_illegal <= w_illegal;
        end
    end

    // On response completion, count the operation and hand priority to the other requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_count <= 16'd0;
            r_ptr      <= 1'b0;
        end else if (w_done) begin
            r_op_count <= r_op_count + 16'd1;
            r_ptr      <= ~r_id;
        end
    end

    assign bus.a_ready     = w_grant_a;
    assign bus.b_ready     = w_grant_b;
    assign bus.rsp_valid   = w_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_illegal = r_rsp_illegal;
    assign bus.busy        = w_busy;
    assign bus.op_count    = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter.
// Every expected value is hand-computed.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(16)) bus ();

    alu_arbiter #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_cnt = 16'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [15:0] n1, input logic [15:0] n2, input logic [3:0] op);
        bus.a_valid  = v;
        bus.a_num1   = n1;
        bus.a_num2   = n2;
        bus.a_opcode = op;
    endtask

    task automatic drive_b(input logic v, input logic [15:0] n1, input logic [15:0] n2, input logic [3:0] op);
        bus.b_valid  = v;
        bus.b_num1   = n1;
        bus.b_num2   = n2;
        bus.b_opcode = op;
    endtask

    // One full transaction from the current IDLE point.
    // The response is held back for 'hold' cycles.
    task automatic do_op(input string tag, input logic exp_id, input logic [15:0] exp_data,
                         input logic exp_ill, input int hold);
        int waited = 0;
        #1;
        while (!(bus.a_ready || bus.b_ready) && waited < 8) begin
            tick();
            waited++;
        end
        if (!(bus.a_ready || bus.b_ready)) begin
            check({tag, "_grant_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_one_grant"}, 32'(bus.a_ready & bus.b_ready), 32'd0);
        check({tag, "_grant_id"}, 32'(bus.b_ready), 32'(exp_id));
        tick();
        check({tag, "_exec_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_exec_ready"}, 32'({bus.a_ready, bus.b_ready}), 32'd0);
        tick();
        for (int i = 0; i <= hold; i++) begin
            check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
            check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'(exp_id));
            check({tag, "_rsp_illegal"}, 32'(bus.rsp_illegal), 32'(exp_ill));
            if (i < hold) begin
                check({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
                check({tag, "_hold_ready"}, 32'({bus.a_ready, bus.b_ready}), 32'd0);
                bus.a_num1 = bus.a_num1 ^ 16'hFFFF;
                tick();
            end
        end
        bus.rsp_ready = 1'b1;
        check({tag, "_cnt_before"}, 32'(bus.op_count), 32'(exp_cnt));
        tick();
        bus.rsp_ready = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        check({tag, "_done_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_op_count"}, 32'(bus.op_count), 32'(exp_cnt));
    endtask

    initial begin
        reset = 1'b1;
        drive_a(1'b0, 16'h0, 16'h0, 4'h0);
        drive_b(1'b0, 16'h0, 16'h0, 4'h0);
        bus.rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
        check("rst_op_count", 32'(bus.op_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'({bus.a_ready, bus.b_ready}), 32'd0);
        reset = 1'b0;

        // Single A op: 5 + 3
        drive_a(1'b1, 16'h0005, 16'h0003, 4'b0001);
        do_op("single_a", 1'b0, 16'h0008, 1'b0, 0);
        drive_a(1'b0, 16'h0, 16'h0, 4'h0);

        // rsp_ready while idle is ignored
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        check("idle_rdy_count", 32'(bus.op_count), 32'd1);
        check("idle_rdy_busy", 32'(bus.busy), 32'd0);
        check("idle_rdy_valid", 32'(bus.rsp_valid), 32'd0);
        bus.rsp_ready = 1'b0;

        // Mid-cycle reset pulse clears the counter
        #2;
        reset = 1'b1;
        #1;
        check("pulse_op_count", 32'(bus.op_count), 32'd0);
        #1;
        reset = 1'b0;
        exp_cnt = 16'd0;
        tick();

        // Contention, alternating A then B
        drive_a(1'b1, 16'h0003, 16'h0005, 4'b0010);
        drive_b(1'b1, 16'h00FF, 16'h0F0F, 4'b0101);
        do_op("cont1_a", 1'b0, 16'hFFFE, 1'b0, 0);
        do_op("cont2_b", 1'b1, 16'h0FF0, 1'b0, 0);
        do_op("cont3_a", 1'b0, 16'hFFFE, 1'b0, 0);
        do_op("cont4_b", 1'b1, 16'h0FF0, 1'b0, 0);
        drive_a(1'b0, 16'h0, 16'h0, 4'h0);
        drive_b(1'b0, 16'h0, 16'h0, 4'h0);

        // Backpressure: 5 cycles of rsp_ready=0, with B pending throughout
        drive_a(1'b1, 16'hF0F0, 16'h3C3C, 4'b0011);
        drive_b(1'b1, 16'h1111, 16'h2222, 4'b0001);
        do_op("bp", 1'b0, 16'h3030, 1'b0, 5);
        drive_a(1'b0, 16'h0, 16'h0, 4'h0);
        drive_b(1'b0, 16'h0, 16'h0, 4'h0);

        // Illegal opcode from B
        drive_b(1'b1, 16'h1234, 16'h0001, 4'b1111);
        do_op("illegal", 1'b1, 16'h0000, 1'b1, 0);
        drive_b(1'b0, 16'h0, 16'h0, 4'h0);

        // Add overflow wraps, then OR
        drive_a(1'b1, 16'hFFFF, 16'h0002, 4'b0001);
        do_op("add_wrap", 1'b0, 16'h0001, 1'b0, 0);
        drive_a(1'b1, 16'h1200, 16'h0034, 4'b0100);
        do_op("or", 1'b0, 16'h1234, 1'b0, 0);
        drive_a(1'b0, 16'h0, 16'h0, 4'h0);

        // Reset asserted mid-cycle while the response is pending
        drive_a(1'b1, 16'h0001, 16'h0001, 4'b0001);
        tick();
        drive_a(1'b0, 16'h0, 16'h0, 4'h0);
        tick();
        check("rr_pre_valid", 32'(bus.rsp_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rr_busy", 32'(bus.busy), 32'd0);
        check("rr_op_count", 32'(bus.op_count), 32'd0);
        check("rr_rsp_data", 32'(bus.rsp_data), 32'd0);
        #1;
        reset = 1'b0;
        exp_cnt = 16'd0;
        drive_a(1'b1, 16'h0007, 16'h0001, 4'b0010);
        drive_b(1'b1, 16'h0002, 16'h0002, 4'b0001);
        do_op("post_rst", 1'b0, 16'h0006, 1'b0, 0);
        drive_a(1'b0, 16'h0, 16'h0, 4'h0);
        drive_b(1'b0, 16'h0, 16'h0, 4'h0);

        // Counter wrap, preloaded two short of rollover
        force dut.r_op_count = 16'hFFFE;
        #1;
        release dut.r_op_count;
        exp_cnt = 16'hFFFE;
        drive_a(1'b1, 16'h0A0A, 16'h0505, 4'b0101);
        do_op("wrap1", 1'b0, 16'h0F0F, 1'b0, 0);
        do_op("wrap2", 1'b0, 16'h0F0F, 1'b0, 0);
        drive_a(1'b0, 16'h0, 16'h0, 4'h0);
        check("wrap_zero", 32'(bus.op_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
